rdptr_empty_fwft: RTL and testbench
===================================

Name: rdptr_empty_fwft

Overview:
- Read-side controller of the asynchronous FIFO; pairs with the write-pointer/full logic on the opposite clock domain.
- Synchronises the incoming write Gray pointer into the read domain and maintains the read binary/Gray pointers.
- Issues synchronous reads to the dual-port memory and presents data through a 2-entry first-word-fall-through (FWFT) output buffer with valid/ready handshake.
- Exports its read Gray pointer to the write domain so the write side can generate full.

Parameters:
- ADDRSIZE, 8, memory address width; pointers are ADDRSIZE+1 bits.
- DATASIZE, 8, data word width.
- SYNC_STAGES, 2, flops in the write-pointer synchroniser; legal range 2..4.
- AE_THRESH, 4, almost_empty asserts when rd_level <= AE_THRESH.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  asynchronous, active-high reset.
- wr_gray_ptr  in  ADDRSIZE+1  write Gray pointer, asynchronous to rd_clk.
- rd_gray_ptr  out  ADDRSIZE+1  registered read Gray pointer, to the write-domain synchroniser.
- mem_rd_en  out  1  memory read strobe.
- rd_addr  out  ADDRSIZE  memory read address, equal to rd_bin[ADDRSIZE-1:0].
- mem_rd_data  in  DATASIZE  memory read data, valid 1 cycle after mem_rd_en.
- dout  out  DATASIZE  head-of-FIFO data.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout this cycle.
- empty  out  1  equal to !dout_valid.
- almost_empty  out  1  low-level flag.
- rd_level  out  ADDRSIZE+1  words held (memory plus buffer), registered.

Behaviour:
- Reset (asynchronous, rd_rst=1) clears all state to 0: synchroniser, rd_bin, rd_gray_ptr, buffer, inflight.
  - Outputs during reset: dout=0, dout_valid=0, empty=1, mem_rd_en=0, rd_level=0, almost_empty=1.
  - A reset asserted mid-transfer discards buffered and in-flight words.
- Synchroniser: wr_gray_ptr passes through SYNC_STAGES flops to give wq; Gray-to-binary conversion of wq gives wr_bin_s.
- ptr_empty = (rd_gray_next_candidate == wq) is not used. Instead, ptr_empty = (rd_bin == wr_bin_s), evaluated combinationally on registered values.
- pop = dout_valid & dout_ready.
- Issue rule: mem_rd_en = !ptr_empty & ((out_cnt + inflight - pop) < 2). This sustains 1 word/cycle.
- On mem_rd_en:
  - rd_bin <= rd_bin+1, with natural wrap at 2^(ADDRSIZE+1).
  - rd_gray_ptr <= next_bin ^ (next_bin>>1), registered in the same cycle.
  - inflight <= 1.
- The cycle after an issue: mem_rd_data is pushed into the buffer tail.
  - Push and pop in the same cycle are legal; out_cnt stays unchanged.
- Buffer: 2 entries, head drives dout. dout_valid = (out_cnt != 0). Pop shifts entry1 to entry0.
- dout and dout_valid must be stable while dout_valid=1 and dout_ready=0.
- First-word latency (buffer empty, no read in progress):
  - write pointer change visible after SYNC_STAGES cycles;
  - then mem_rd_en in the next cycle;
  - dout_valid 2 cycles after mem_rd_en.
- Back-pressure: with dout_ready=0 and out_cnt=2, no further issues occur. No word is ever dropped or duplicated.
- Wrap-around: rd_addr wraps from 2^ADDRSIZE-1 to 0 while the MSB of rd_bin toggles. Equality with wr_bin_s correctly means empty, not full.
- rd_level <= (wr_bin_s - rd_bin) + out_cnt + inflight, modulo 2^(ADDRSIZE+1), registered. It is never greater than 2^ADDRSIZE.
- almost_empty is registered: (rd_level_next <= AE_THRESH).

Optional Feature:
- RD_LEVEL_EN defined: rd_level and almost_empty are computed as above.
- RD_LEVEL_EN undefined: the level subtractor and registers are removed; rd_level tied to 0; almost_empty tied to empty. All other behaviour is identical.

Decomposition:
- Shared package holds the bin2gray and gray2bin functions, shared with the write side, plus the default ADDRSIZE/DATASIZE constants.
- One natural sub-module, sync_ptr: SYNC_STAGES-deep, ADDRSIZE+1-wide flop chain. It is reused by the write domain for rd_gray_ptr.

Test Plan:
- Reset, then wr_gray_ptr=0 held → empty=1, mem_rd_en never asserts, rd_level=0.
- Step wr_gray_ptr 0→1 (one word 0xA5 at addr 0), dout_ready=0 → mem_rd_en pulses once with rd_addr=0.
  - Then dout_valid=1, dout=0xA5, rd_gray_ptr=1, held until dout_ready=1; then empty=1.
- 8 words present, dout_ready=1 continuously → 8 consecutive dout_valid cycles, in-order data, rd_level counts down 8→0 (RD_LEVEL_EN).
- 8 words present, dout_ready=0 → exactly 2 issues, out_cnt=2, rd_level=8. Releasing dout_ready yields all 8 in order with no gap after the pipeline refills.
- ADDRSIZE=3: stream 40 words with random dout_ready → rd_addr wraps 7→0 five times, no loss or duplication, rd_gray_ptr changes one bit per step.
- Assert rd_rst mid-stream with out_cnt=2 → dout_valid=0 and rd_gray_ptr=0 immediately (asynchronously); no mem_rd_en until wq reflects a nonzero pointer after release.

Source files
------------

// File: rtl/rdptr_empty_fwft_pkg.sv
// Shared pointer helpers for both halves of the asynchronous FIFO.
// Holds the Gray/binary conversions and the default address and data widths.
package rdptr_empty_fwft_pkg;

    localparam int ADDRSIZE_DEF = 8;
    localparam int DATASIZE_DEF = 8;

    // Conversions work on a wide container; callers zero-extend and truncate.
    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin = gray;
        for (int i = 1; i < PTR_MAX; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/rdptr_empty_fwft_sync_ptr.sv
// Multi-flop synchroniser for a Gray-coded FIFO pointer crossing clock domains.
// Shared by both FIFO sides; STAGES is expected to be in the range 2..4.
module sync_ptr #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // NOTE: non-blocking assignments make each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rdptr_empty_fwft.sv
// Read-side controller of the async FIFO: pointer sync, empty detection, FWFT output buffer.
// Define RD_LEVEL_EN to build the registered rd_level / almost_empty logic.
module rdptr_empty_fwft
    import rdptr_empty_fwft_pkg::*;
#(
    parameter int ADDRSIZE    = ADDRSIZE_DEF,
    parameter int DATASIZE    = DATASIZE_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 4
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic [ADDRSIZE:0]   wr_gray_ptr,
    output logic [ADDRSIZE:0]   rd_gray_ptr,
    output logic                mem_rd_en,
    output logic [ADDRSIZE-1:0] rd_addr,
    input  logic [DATASIZE-1:0] mem_rd_data,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   rd_level
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]       wq;
    logic [PW-1:0]       wr_bin_s;
    logic [PW-1:0]       rd_bin;
    logic [PW-1:0]       rd_bin_next;
    logic [1:0]          out_cnt;
    logic [2:0]          occ_after_pop;
    logic                inflight;
    logic                pop;
    logic                push;
    logic                ptr_empty;
    logic [DATASIZE-1:0] buf0;
    logic [DATASIZE-1:0] buf1;

    sync_ptr #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_wr_ptr (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_gray_ptr),
        .q   (wq)
    );

    assign wr_bin_s  = PW'(gray2bin(ptr_max_t'(wq)));
    // Full binary compare: a wrapped MSB difference means full, equality means empty.
    assign ptr_empty = (rd_bin == wr_bin_s);

    assign pop  = dout_valid & dout_ready;
    assign push = inflight;

    // Buffer occupancy next cycle, before any new issue lands; also the next out_cnt.
    assign occ_after_pop = 3'(out_cnt) + 3'(inflight) - 3'(pop);
    assign mem_rd_en     = !ptr_empty && (occ_after_pop < 3'd2);

    assign rd_bin_next = rd_bin + PW'(1);
    assign rd_addr     = rd_bin[ADDRSIZE-1:0];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin      <= '0;
            rd_gray_ptr <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                rd_bin      <= rd_bin_next;
                rd_gray_ptr <= PW'(bin2gray(ptr_max_t'(rd_bin_next)));
            end
        end
    end

    // NOTE: the two buffer entries are reset so dout reads 0 in reset; a RAM array would not be.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            out_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            out_cnt <= occ_after_pop[1:0];
            case ({push, pop})
                2'b10: begin
                    if (out_cnt == 2'd0) buf0 <= mem_rd_data;
                    else                 buf1 <= mem_rd_data;
                end
                2'b01: buf0 <= buf1;
                2'b11: begin
                    if (out_cnt == 2'd1) begin
                        buf0 <= mem_rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout       = buf0;
    assign dout_valid = (out_cnt != 2'd0);
    assign empty      = !dout_valid;

`ifdef RD_LEVEL_EN
    logic [PW-1:0] rd_level_next;

    // Unread words in memory plus words buffered or in flight; wraps with the pointers.
    assign rd_level_next = (wr_bin_s - rd_bin) + PW'(out_cnt) + PW'(inflight);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_level     <= rd_level_next;
            almost_empty <= (int'(rd_level_next) <= AE_THRESH);
        end
    end
`else
    assign rd_level     = '0;
    assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_rdptr_empty_fwft.sv
// Self-checking bench for rdptr_empty_fwft at ADDRSIZE=3 so pointer wrap is reached quickly.
// A scoreboard queue and a delayed write-count history give the expected data and level.
module tb_rdptr_empty_fwft;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int AE    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic [PW-1:0] wr_gray_ptr;
    logic [PW-1:0] rd_gray_ptr;
    logic          mem_rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;

    int checks = 0;
    int errors = 0;

    always #5 rd_clk = ~rd_clk;

    rdptr_empty_fwft #(
        .ADDRSIZE    (AW),
        .DATASIZE    (DW),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .wr_gray_ptr  (wr_gray_ptr),
        .rd_gray_ptr  (rd_gray_ptr),
        .mem_rd_en    (mem_rd_en),
        .rd_addr      (rd_addr),
        .mem_rd_data  (mem_rd_data),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level)
    );

    // Dual-port memory with a one-cycle registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= mem[rd_addr];
    end

    // Reference state: words written, words seen through the synchroniser, words consumed.
    int            wr_cnt = 0;
    int            pops = 0;
    int            issues = 0;
    int            wraps = 0;
    int            exp_level = 0;
    logic [AW-1:0] last_addr = '0;
    int            hist [$];
    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] prev_gray = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            hist.delete();
            pops      = 0;
            issues    = 0;
            exp_level = 0;
        end else begin
            exp_level = ((hist.size() >= SS) ? hist[hist.size() - SS] : 0) - pops;
            hist.push_back(wr_cnt);
            if (hist.size() > SS) void'(hist.pop_front());
            if (dout_valid && dout_ready) pops++;
            if (mem_rd_en) begin
                if (issues > 0 && last_addr == AW'(DEPTH - 1) && rd_addr == '0) wraps++;
                last_addr = rd_addr;
                issues++;
            end
        end
    end

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_checks();
        check("empty_flag", 32'(empty), 32'(!dout_valid));
`ifdef RD_LEVEL_EN
        check("rd_level", 32'(rd_level), 32'(PW'(exp_level)));
        check("almost_empty", 32'(almost_empty), 32'(exp_level <= AE));
`else
        check("rd_level", 32'(rd_level), 32'(0));
        check("almost_empty", 32'(almost_empty), 32'(!dout_valid));
`endif
        check("rd_gray", 32'(rd_gray_ptr), 32'(to_gray(issues)));
        check("gray_step", 32'($countones(rd_gray_ptr ^ prev_gray) <= 1), 32'(1));
        prev_gray = rd_gray_ptr;
        if (prev_hold) begin
            check("hold_valid", 32'(dout_valid), 32'(1));
            check("hold_data", 32'(dout), 32'(prev_dout));
        end
    endtask

    // One cycle: sample at negedge, choose ready, score the word popped at the next edge.
    task automatic step(input logic ready);
        @(negedge rd_clk);
        cycle_checks();
        dout_ready = ready;
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) check("spurious_word", 32'(dout), 32'hFFFF_FFFF);
            else                   check("data", 32'(dout), 32'(exp_q.pop_front()));
        end
        prev_hold = dout_valid && !dout_ready;
        prev_dout = dout;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_cnt % DEPTH] = d;
        exp_q.push_back(d);
        wr_cnt++;
    endtask

    task automatic publish();
        wr_gray_ptr = to_gray(wr_cnt);
    endtask

    task automatic drain(output int nvalid, output int gaps);
        nvalid = 0;
        gaps   = 0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step(1'b1);
            if (dout_valid)      nvalid++;
            else if (nvalid > 0) gaps++;
        end
    endtask

    int lat;
    int nvalid;
    int gaps;
    int base;
    int written;
    int start_addr;
    int exp_wraps;
    int wraps_before;

    initial begin
        rd_rst      = 1'b1;
        wr_gray_ptr = '0;
        dout_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(negedge rd_clk);

        check("rst_empty", 32'(empty), 32'(1));
        check("rst_dout_valid", 32'(dout_valid), 32'(0));
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
        check("rst_rd_level", 32'(rd_level), 32'(0));
        check("rst_almost_empty", 32'(almost_empty), 32'(1));
        check("rst_rd_gray", 32'(rd_gray_ptr), 32'(0));
        rd_rst = 1'b0;

        // Idle with the write pointer held at zero.
        repeat (10) step(1'b0);
        check("idle_issues", 32'(issues), 32'(0));
        check("idle_empty", 32'(empty), 32'(1));

        // One word, consumer stalled.
        write_word(8'hA5);
        publish();
        lat = 0;
        while (!dout_valid && lat < 20) begin
            step(1'b0);
            lat++;
        end
        check("first_word_latency", 32'(lat), 32'(SS + 2));
        check("single_addr", 32'(last_addr), 32'(0));
        repeat (5) step(1'b0);
        check("single_issues", 32'(issues), 32'(1));
        check("single_valid", 32'(dout_valid), 32'(1));
        check("single_dout", 32'(dout), 32'(8'hA5));
        check("single_gray", 32'(rd_gray_ptr), 32'(1));
`ifdef RD_LEVEL_EN
        check("single_level", 32'(rd_level), 32'(1));
`endif
        step(1'b1);
        step(1'b0);
        check("single_empty_after_pop", 32'(empty), 32'(1));
        check("single_drained", 32'(exp_q.size()), 32'(0));

        // Eight words with the consumer always ready.
        for (int i = 0; i < DEPTH; i++) write_word(DW'($urandom));
        publish();
        drain(nvalid, gaps);
        check("stream_count", 32'(nvalid), 32'(DEPTH));
        check("stream_gaps", 32'(gaps), 32'(0));
        check("stream_drained", 32'(exp_q.size()), 32'(0));
        repeat (4) step(1'b0);
        check("stream_empty", 32'(empty), 32'(1));

        // Eight words with back-pressure, then release.
        base = issues;
        for (int i = 0; i < DEPTH; i++) write_word(DW'($urandom));
        publish();
        repeat (12) step(1'b0);
        check("bp_issues", 32'(issues - base), 32'(2));
        check("bp_valid", 32'(dout_valid), 32'(1));
`ifdef RD_LEVEL_EN
        check("bp_level_full", 32'(rd_level), 32'(DEPTH));
`endif
        drain(nvalid, gaps);
        check("bp_count", 32'(nvalid), 32'(DEPTH));
        check("bp_gaps", 32'(gaps), 32'(0));
        check("bp_drained", 32'(exp_q.size()), 32'(0));
        repeat (4) step(1'b0);

        // Reset while the output buffer is full.
        for (int i = 0; i < 4; i++) write_word(DW'($urandom));
        publish();
        repeat (10) step(1'b0);
        check("pre_rst_valid", 32'(dout_valid), 32'(1));
        #1;
        rd_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(dout_valid), 32'(0));
        check("async_rst_gray", 32'(rd_gray_ptr), 32'(0));
        check("async_rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
        wr_cnt      = 0;
        wr_gray_ptr = '0;
        exp_q.delete();
        prev_hold = 1'b0;
        prev_gray = '0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        repeat (8) step(1'b0);
        check("post_rst_issues", 32'(issues), 32'(0));
        check("post_rst_empty", 32'(empty), 32'(1));
        write_word(8'h3C);
        publish();
        lat = 0;
        while (!dout_valid && lat < 20) begin
            step(1'b0);
            lat++;
        end
        check("post_rst_latency", 32'(lat), 32'(SS + 2));
        check("post_rst_dout", 32'(dout), 32'(8'h3C));
        step(1'b1);
        step(1'b0);

        // Forty words with random ready; read address wraps several times.
        start_addr   = issues % DEPTH;
        wraps_before = wraps;
        base         = issues;
        exp_wraps    = 0;
        for (int k = 1; k < 40; k++) begin
            if ((start_addr + k) % DEPTH == 0) exp_wraps++;
        end
        written = 0;
        for (int c = 0; c < 2000 && (written < 40 || exp_q.size() > 0); c++) begin
            step(1'($urandom_range(0, 2) != 0));
            if (written < 40 && (wr_cnt - pops) < DEPTH && $urandom_range(0, 3) != 0) begin
                write_word(DW'($urandom));
                publish();
                written++;
            end
        end
        check("wrap_written", 32'(written), 32'(40));
        check("wrap_drained", 32'(exp_q.size()), 32'(0));
        check("wrap_issues", 32'(issues - base), 32'(40));
        check("wrap_count", 32'(wraps - wraps_before), 32'(exp_wraps));
        repeat (6) step(1'b0);
        check("final_empty", 32'(empty), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
